can_bit_destuffer: RTL and testbench

Sample-point consumer for the CAN receive path, directly downstream of `baudclock`. It detects the rising edge of `baud` to sample `rx`, and establishes bus idle after `IDLE_BITS` recessive samples. It then detects start-of-frame, removes stuff bits and flags stuff violations, presenting a destuffed bit stream with a one-cycle valid strobe to the frame decoder.

---
 rtl/can_bit_destuffer.sv | 195 +++++++++++++++++++
 tb/tb_can_bit_destuffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer
//
// Sample-point consumer for the CAN receive path. It sits directly behind the
// baud clock generator and does the following:
//   - takes one sample of rx on each rising edge of baud;
//   - declares the bus idle after IDLE_BITS consecutive recessive samples;
//   - detects start-of-frame;
//   - removes stuff bits and flags stuff violations;
//   - delivers the destuffed stream to the frame decoder, one bit per
//     single-cycle bit_valid strobe.
//
// Parameters
//   IDLE_BITS  consecutive recessive samples needed to declare bus idle (<=15)
//   RUN_MAX    identical-bit run length after which a stuff bit is expected
//
// Ports
//   clk         system clock (same domain as the baud clock generator)
//   rst         asynchronous, active-low reset
//   rx          bus level, 1 = recessive, synchronous to clk
//   baud        baud output of the baud clock generator; rising edge = sample
//   lock        baud clock generator lock, active high
//   glitch      baud clock generator glitch flag (see macro below)
//   stuff_en    from the frame decoder: enables stuff removal and checking
//   frame_done  one-cycle end-of-frame pulse from the frame decoder
//   bit_out     destuffed bit, valid while bit_valid is high
//   bit_valid   one-cycle strobe per delivered bit
//   sof         one-cycle strobe, coincident with the SOF bit's bit_valid
//   stuff_err   one-cycle strobe on a stuff violation or a glitch abort
//   idle        high while the bus is idle (state IDLE)
//   in_frame    high while a frame is being received (state FRAME)
//
// Optional feature
//   CAN_DESTUFF_GLITCH_ABORT_EN
//     Defined:   glitch=1 in FRAME aborts the frame with a stuff_err pulse.
//     Undefined: glitch is ignored; the port is kept for pin compatibility.
// ---------------------------------------------------------------------------
module can_bit_destuffer #(
    parameter int IDLE_BITS = 11,
    parameter int RUN_MAX   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic baud,
    input  logic lock,
    input  logic glitch,
    input  logic stuff_en,
    input  logic frame_done,
    output logic bit_out,
    output logic bit_valid,
    output logic sof,
    output logic stuff_err,
    output logic idle,
    output logic in_frame
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE_WAIT = 2'd1,
        IDLE      = 2'd2,
        FRAME     = 2'd3
    } state_t;

    localparam logic [3:0] IDLE_MAX = 4'(IDLE_BITS);
    localparam logic [2:0] RUN_SAT  = 3'(RUN_MAX);

    state_t      state_reg;
    logic        baud_q;
    logic [3:0]  idle_cnt_reg;
    logic [2:0]  run_len_reg;
    logic        last_bit_reg;

    logic        sample;
    logic        glitch_abort;
    logic [3:0]  idle_cnt_inc;
    logic [2:0]  run_len_inc;
    logic        stuff_slot;

    // One sample per rising edge of baud.
    assign sample = baud & ~baud_q;

`ifdef CAN_DESTUFF_GLITCH_ABORT_EN
    assign glitch_abort = glitch;
`else
    // Pin kept for compatibility; the AND with zero keeps it formally read.
    assign glitch_abort = glitch & 1'b0;
`endif

    // Saturating increments.
    assign idle_cnt_inc = (idle_cnt_reg >= IDLE_MAX) ? IDLE_MAX : idle_cnt_reg + 4'd1;
    assign run_len_inc  = (run_len_reg  >= RUN_SAT)  ? RUN_SAT  : run_len_reg  + 3'd1;

    // After RUN_MAX identical bits the next sample must be a complementary
    // stuff bit. run_len keeps tracking while stuffing is disabled, so
    // re-enabling mid-run takes effect on the very next sample.
    assign stuff_slot = stuff_en && (run_len_reg >= RUN_SAT);

    assign idle     = (state_reg == IDLE);
    assign in_frame = (state_reg == FRAME);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= WAIT_LOCK;
            baud_q       <= 1'b0;
            idle_cnt_reg <= 4'd0;
            run_len_reg  <= 3'd0;
            last_bit_reg <= 1'b1;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            sof          <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            baud_q    <= baud;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            sof       <= 1'b0;
            stuff_err <= 1'b0;

            if (!lock) begin
                // Loss of lock abandons everything silently.
                state_reg <= WAIT_LOCK;
            end else begin
                case (state_reg)
                    WAIT_LOCK: begin
                        // Any sample in this cycle is ignored; counting
                        // starts with the next one.
                        idle_cnt_reg <= 4'd0;
                        state_reg    <= IDLE_WAIT;
                    end

                    IDLE_WAIT: begin
                        if (sample) begin
                            if (rx) begin
                                idle_cnt_reg <= idle_cnt_inc;
                                if (idle_cnt_inc >= IDLE_MAX) begin
                                    state_reg <= IDLE;
                                end
                            end else begin
                                idle_cnt_reg <= 4'd0;
                            end
                        end
                    end

                    IDLE: begin
                        if (sample && !rx) begin
                            sof          <= 1'b1;
                            bit_valid    <= 1'b1;
                            bit_out      <= 1'b0;
                            run_len_reg  <= 3'd1;
                            last_bit_reg <= 1'b0;
                            state_reg    <= FRAME;
                        end
                    end

                    FRAME: begin
                        if (glitch_abort) begin
                            stuff_err    <= 1'b1;
                            idle_cnt_reg <= 4'd0;
                            state_reg    <= IDLE_WAIT;
                        end else if (frame_done) begin
                            // A sample coincident with frame_done is dropped.
                            idle_cnt_reg <= 4'd0;
                            state_reg    <= IDLE_WAIT;
                        end else if (sample) begin
                            if (stuff_slot) begin
                                if (rx != last_bit_reg) begin
                                    // Valid stuff bit: drop it and start a new run.
                                    run_len_reg  <= 3'd1;
                                    last_bit_reg <= rx;
                                end else begin
                                    stuff_err    <= 1'b1;
                                    idle_cnt_reg <= 4'd0;
                                    state_reg    <= IDLE_WAIT;
                                end
                            end else begin
                                bit_valid <= 1'b1;
                                bit_out   <= rx;
                                if (rx == last_bit_reg) begin
                                    run_len_reg <= run_len_inc;
                                end else begin
                                    run_len_reg  <= 3'd1;
                                    last_bit_reg <= rx;
                                end
                            end
                        end
                    end

                    default: state_reg <= WAIT_LOCK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// tb_can_bit_destuffer
//
// Directed testbench for can_bit_destuffer. A negedge monitor collects
// delivered bits and strobe counts; the stimulus thread compares them with
// hand-computed expectations through a single check task.
// ---------------------------------------------------------------------------
module tb_can_bit_destuffer;

    logic clk        = 1'b0;
    logic rst        = 1'b0;
    logic rx         = 1'b1;
    logic baud       = 1'b0;
    logic lock       = 1'b0;
    logic glitch     = 1'b0;
    logic stuff_en   = 1'b0;
    logic frame_done = 1'b0;
    logic bit_out, bit_valid, sof, stuff_err, idle, in_frame;

    can_bit_destuffer #(.IDLE_BITS(11), .RUN_MAX(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .baud       (baud),
        .lock       (lock),
        .glitch     (glitch),
        .stuff_en   (stuff_en),
        .frame_done (frame_done),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .sof        (sof),
        .stuff_err  (stuff_err),
        .idle       (idle),
        .in_frame   (in_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic got_q[$];
    int   sof_cnt = 0;
    int   err_cnt = 0;
    int   sof_bad = 0;

    // Monitor: strobes are registered, so each is seen at exactly one negedge.
    always @(negedge clk) begin
        if (bit_valid) got_q.push_back(bit_out);
        if (sof) sof_cnt++;
        if (stuff_err) err_cnt++;
        if (sof && !bit_valid) sof_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [31:0] packed_bits();
        logic [31:0] v = '0;
        for (int i = 0; i < got_q.size() && i < 32; i++) v[i] = got_q[i];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        sof_cnt = 0;
        err_cnt = 0;
        sof_bad = 0;
    endtask

    // One baud rising edge with rx=b, then spacing so the next call is fresh.
    task automatic do_sample(input logic b);
        rx   = b;
        baud = 1'b1;
        tick(1);
        baud = 1'b0;
        tick(2);
    endtask

    // Eleven recessive samples: idle must rise on the 11th and not before.
    task automatic go_idle(input string tag);
        for (int i = 0; i < 10; i++) do_sample(1'b1);
        check({tag, "_idle_after10"}, 32'(idle), 32'd0);
        do_sample(1'b1);
        check({tag, "_idle_after11"}, 32'(idle), 32'd1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst  = 1'b0;
        lock = 1'b1;
        tick(3);
        check("reset_outputs", 32'({bit_out, bit_valid, sof, stuff_err, idle, in_frame}), 32'd0);
        rst = 1'b1;
        tick(2);
        go_idle("init");
        check("init_in_frame", 32'(in_frame), 32'd0);

        // ---------------- A: valid stuff bit removed ----------------
        clear_mon();
        stuff_en = 1'b1;
        do_sample(1'b0); do_sample(1'b0); do_sample(1'b0); do_sample(1'b0);
        do_sample(1'b0); do_sample(1'b1); do_sample(1'b0);
        check("A_in_frame", 32'(in_frame), 32'd1);
        check("A_len", 32'(got_q.size()), 32'd6);
        check("A_bits", packed_bits(), 32'h0);
        check("A_sof_cnt", 32'(sof_cnt), 32'd1);
        check("A_sof_with_valid", 32'(sof_bad), 32'd0);
        check("A_stuff_err", 32'(err_cnt), 32'd0);
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        check("A_done_flags", 32'({idle, in_frame}), 32'd0);

        // ---------------- B: stuff violation ----------------
        go_idle("B_pre");
        clear_mon();
        stuff_en = 1'b1;
        for (int i = 0; i < 6; i++) do_sample(1'b0);
        check("B_len", 32'(got_q.size()), 32'd5);
        check("B_bits", packed_bits(), 32'h0);
        check("B_stuff_err", 32'(err_cnt), 32'd1);
        check("B_flags", 32'({idle, in_frame}), 32'd0);
        go_idle("B_recover");

        // ---------------- C: no stuffing, frame_done on a sample ----------------
        clear_mon();
        stuff_en = 1'b0;
        do_sample(1'b0);
        for (int i = 0; i < 8; i++) do_sample(1'b1);
        rx         = 1'b0;
        baud       = 1'b1;
        frame_done = 1'b1;
        tick(1);
        baud       = 1'b0;
        frame_done = 1'b0;
        tick(2);
        check("C_len", 32'(got_q.size()), 32'd9);
        check("C_bits", packed_bits(), 32'h1FE);
        check("C_stuff_err", 32'(err_cnt), 32'd0);
        check("C_flags", 32'({idle, in_frame}), 32'd0);
        go_idle("C_recover");

        // ---------------- C2: stuff_en re-asserted at full run ----------------
        clear_mon();
        stuff_en = 1'b0;
        do_sample(1'b0);
        for (int i = 0; i < 5; i++) do_sample(1'b1);
        stuff_en = 1'b1;
        do_sample(1'b1);
        check("C2_len", 32'(got_q.size()), 32'd6);
        check("C2_bits", packed_bits(), 32'h3E);
        check("C2_stuff_err", 32'(err_cnt), 32'd1);
        check("C2_in_frame", 32'(in_frame), 32'd0);
        go_idle("C2_recover");

        // ---------------- D: lock lost mid-frame ----------------
        clear_mon();
        stuff_en = 1'b1;
        do_sample(1'b0); do_sample(1'b1); do_sample(1'b0);
        check("D_in_frame", 32'(in_frame), 32'd1);
        lock = 1'b0;
        tick(1);
        check("D_lock_low_flags", 32'({idle, in_frame}), 32'd0);
        for (int i = 0; i < 3; i++) do_sample(1'b0);
        check("D_len", 32'(got_q.size()), 32'd3);
        check("D_bits", packed_bits(), 32'h2);
        check("D_stuff_err", 32'(err_cnt), 32'd0);
        // Sample coincident with lock returning high must not count.
        rx   = 1'b1;
        lock = 1'b1;
        baud = 1'b1;
        tick(1);
        baud = 1'b0;
        tick(2);
        go_idle("D_recover");
        check("D_no_new_bits", 32'(got_q.size()), 32'd3);

        // ---------------- E: glitch in frame ----------------
        clear_mon();
        do_sample(1'b0); do_sample(1'b1);
        check("E_in_frame", 32'(in_frame), 32'd1);
        glitch = 1'b1;
        tick(1);
        glitch = 1'b0;
`ifdef CAN_DESTUFF_GLITCH_ABORT_EN
        check("E_stuff_err_next", 32'(stuff_err), 32'd1);
        check("E_in_frame_after", 32'(in_frame), 32'd0);
`else
        check("E_stuff_err_next", 32'(stuff_err), 32'd0);
        check("E_in_frame_after", 32'(in_frame), 32'd1);
`endif
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        check("E_len", 32'(got_q.size()), 32'd2);
        go_idle("E_recover");

        // ---------------- F: reset mid-frame ----------------
        clear_mon();
        do_sample(1'b0); do_sample(1'b0);
        check("F_in_frame", 32'(in_frame), 32'd1);
        rst = 1'b0;
        #2;
        check("F_reset_outputs", 32'({bit_out, bit_valid, sof, stuff_err, idle, in_frame}), 32'd0);
        do_sample(1'b0);
        check("F_reset_hold", 32'({bit_out, bit_valid, sof, stuff_err, idle, in_frame}), 32'd0);
        rst = 1'b1;
        tick(2);
        go_idle("F_recover");
        check("F_in_frame_after", 32'(in_frame), 32'd0);
        check("F_len", 32'(got_q.size()), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
